// File: rtl/full_adder_1bit_if.sv
// full_adder_1bit_if: operand, result and debug-counter bundle for the 1-bit full adder
interface full_adder_1bit_if #(parameter int CNT_W = 16);
  logic a, b, carry_in, in_valid;
  logic s, carry_out, s_q, carry_out_q, out_valid;
  logic [CNT_W-1:0] op_count, carry_count;
  modport master (
    output a, b, carry_in, in_valid,
    input  s, carry_out, s_q, carry_out_q, out_valid, op_count, carry_count
  );
  modport slave (
    input  a, b, carry_in, in_valid,
    output s, carry_out, s_q, carry_out_q, out_valid, op_count, carry_count
  );
endinterface

// File: rtl/full_adder_1bit.sv
// full_adder_1bit: 1-bit full adder with registered result copy and saturating activity counters
module full_adder_1bit #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  full_adder_1bit_if.slave bus
);
  logic sum_q, sum_d, cout_q, cout_d, valid_q, valid_d;
  logic [CNT_W-1:0] op_q, op_d, cy_q, cy_d;
  assign bus.s = bus.a ^ bus.b ^ bus.carry_in;
  assign bus.carry_out = (bus.a & bus.b) | (bus.a & bus.carry_in) | (bus.b & bus.carry_in);
  // Next state: capture the adder result on accepted ops, counters saturate at all-ones
  always_comb begin
    sum_d = bus.in_valid ? bus.s : sum_q;
    cout_d = bus.in_valid ? bus.carry_out : cout_q;
    valid_d = bus.in_valid;
    op_d = (bus.in_valid && op_q != '1) ? op_q + CNT_W'(1) : op_q;
    cy_d = (bus.in_valid && bus.carry_out && cy_q != '1) ? cy_q + CNT_W'(1) : cy_q;
  end
  // Registered path with synchronous active-low reset taking priority over in_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= 1'b0;
      cout_q <= 1'b0;
      valid_q <= 1'b0;
      op_q <= '0;
      cy_q <= '0;
    end else begin
      sum_q <= sum_d;
      cout_q <= cout_d;
      valid_q <= valid_d;
      op_q <= op_d;
      cy_q <= cy_d;
    end
  end
  assign bus.s_q = sum_q;
  assign bus.carry_out_q = cout_q;
  assign bus.out_valid = valid_q;
  assign bus.op_count = op_q;
  assign bus.carry_count = cy_q;
endmodule

// File: tb/tb_full_adder_1bit.sv
// tb_full_adder_1bit: directed-vector check of the combinational adder, registered path and counters
module tb_full_adder_1bit;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;
  full_adder_1bit_if #(.CNT_W(16)) b16 ();
  full_adder_1bit_if #(.CNT_W(2)) b2 ();
  full_adder_1bit #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  full_adder_1bit #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;
  logic [2:0] vec [8] = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b001, 3'b101, 3'b111, 3'b011};
  logic es [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic ec [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive16(input logic [2:0] v, input logic vld);
    b16.a = v[2];
    b16.b = v[1];
    b16.carry_in = v[0];
    b16.in_valid = vld;
  endtask
  initial begin
    rst_n = 1'b0;
    drive16(3'b000, 1'b0);
    b2.a = 1'b0; b2.b = 1'b0; b2.carry_in = 1'b0; b2.in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive16(vec[i], 1'b1);
      #4;
      chk($sformatf("comb_s_%03b", vec[i]), 32'(b16.s), 32'(es[i]));
      chk($sformatf("comb_cout_%03b", vec[i]), 32'(b16.carry_out), 32'(ec[i]));
      @(negedge clk);
    end
    chk("rst_s_q", 32'(b16.s_q), 0);
    chk("rst_carry_out_q", 32'(b16.carry_out_q), 0);
    chk("rst_out_valid", 32'(b16.out_valid), 0);
    chk("rst_op_count", 32'(b16.op_count), 0);
    chk("rst_carry_count", 32'(b16.carry_count), 0);
    rst_n = 1'b1;
    drive16(3'b111, 1'b1);
    @(negedge clk);
    chk("one_s_q", 32'(b16.s_q), 1);
    chk("one_carry_out_q", 32'(b16.carry_out_q), 1);
    chk("one_out_valid", 32'(b16.out_valid), 1);
    drive16(3'b000, 1'b0);
    @(negedge clk);
    chk("idle_out_valid", 32'(b16.out_valid), 0);
    chk("idle_s_q_held", 32'(b16.s_q), 1);
    chk("idle_carry_out_q_held", 32'(b16.carry_out_q), 1);
    chk("idle_op_count", 32'(b16.op_count), 1);
    chk("idle_carry_count", 32'(b16.carry_count), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive16(vec[i], 1'b1);
      @(negedge clk);
      chk($sformatf("reg_s_q_%03b", vec[i]), 32'(b16.s_q), 32'(es[i]));
      chk($sformatf("reg_cout_q_%03b", vec[i]), 32'(b16.carry_out_q), 32'(ec[i]));
      chk($sformatf("reg_valid_%03b", vec[i]), 32'(b16.out_valid), 1);
    end
    chk("stream_op_count", 32'(b16.op_count), 8);
    chk("stream_carry_count", 32'(b16.carry_count), 4);
    drive16(3'b101, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_q", 32'(b16.s_q), 0);
    chk("mid_rst_carry_out_q", 32'(b16.carry_out_q), 0);
    chk("mid_rst_out_valid", 32'(b16.out_valid), 0);
    chk("mid_rst_op_count", 32'(b16.op_count), 0);
    chk("mid_rst_carry_count", 32'(b16.carry_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("resume_out_valid", 32'(b16.out_valid), 1);
    chk("resume_s_q", 32'(b16.s_q), 0);
    chk("resume_carry_out_q", 32'(b16.carry_out_q), 1);
    chk("resume_op_count", 32'(b16.op_count), 1);
    chk("resume_carry_count", 32'(b16.carry_count), 1);
    drive16(3'b000, 1'b0);
    b2.a = 1'b1; b2.b = 1'b1; b2.carry_in = 1'b0; b2.in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("sat_op_count_%0d", k), 32'(b2.op_count), (k > 3) ? 3 : k);
      chk($sformatf("sat_carry_count_%0d", k), 32'(b2.carry_count), (k > 3) ? 3 : k);
    end
    chk("sat_s_q", 32'(b2.s_q), 0);
    chk("sat_carry_out_q", 32'(b2.carry_out_q), 1);
    b2.in_valid = 1'b0;
    @(negedge clk);
    chk("sat_hold_op_count", 32'(b2.op_count), 3);
    chk("sat_hold_carry_count", 32'(b2.carry_count), 3);
    chk("sat_hold_out_valid", 32'(b2.out_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/full_adder_1bit.md
Name: full_adder_1bit

Overview:
- 1-bit binary full adder, used as the leaf cell of ripple-carry adders in the datapath.
- Core function is purely combinational: sum and carry-out of a, b and carry_in.
- Also provides an optional registered copy of the result with a valid flag and saturating activity counters for debug and coverage.
- One clock domain. Reset is synchronous and active-low.

Parameters:
- CNT_W, 16, width of the saturating activity counters.

Ports:
- clk  input  1  single system clock; all registers update on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- a  input  1  addend bit A.
- b  input  1  addend bit B.
- carry_in  input  1  incoming carry bit.
- s  output  1  combinational sum bit.
- carry_out  output  1  combinational carry bit.
- in_valid  input  1  qualifies a/b/carry_in for the registered path.
- s_q  output  1  registered sum.
- carry_out_q  output  1  registered carry.
- out_valid  output  1  registered-result valid flag.
- op_count  output  CNT_W  number of accepted operations, saturating.
- carry_count  output  CNT_W  number of accepted operations with carry_out=1, saturating.

Behaviour:
- Combinational path:
  - s = a XOR b XOR carry_in.
  - carry_out = (a AND b) OR (a AND carry_in) OR (b AND carry_in).
  - Zero latency; independent of clk, rst_n and in_valid; must settle within one delta/propagation step.
  - Outputs must be driven 0/1 (never X/Z) whenever all inputs are 0/1.
- Full truth table, a b cin -> s cout:
  - 000->00, 100->10, 010->10, 110->01
  - 001->10, 101->01, 011->01, 111->11
- Registered path:
  - On a rising clk edge with rst_n=1 and in_valid=1: s_q and carry_out_q load the combinational s and carry_out; out_valid goes to 1.
  - On a rising edge with in_valid=0: out_valid goes to 0; s_q and carry_out_q hold their previous values.
  - Latency is exactly 1 cycle. No backpressure; every valid input is accepted.
- Counters:
  - op_count increments by 1 on each accepted operation (in_valid=1 at the edge).
  - carry_count increments by 1 on each accepted operation whose carry_out=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - The two counters update independently in the same cycle.
- Reset:
  - On a rising clk edge with rst_n=0: s_q=0, carry_out_q=0, out_valid=0, op_count=0, carry_count=0.
  - Reset has priority over in_valid.
  - The combinational s and carry_out are unaffected by reset; they follow the inputs even while rst_n=0.
  - Reset asserted mid-stream discards any pending result: out_valid=0 on the next edge.
- No internal state influences s or carry_out.

Test Plan:
- Apply all 8 input combinations in order 000,100,110,010,001,101,111,011 (a b cin), waiting 10 time units each -> s/carry_out = 0/0, 1/0, 0/1, 1/0, 1/0, 0/1, 1/1, 0/1. Check with case equality (no X).
- Hold rst_n=0 and toggle the inputs -> s/carry_out still follow the truth table; s_q, carry_out_q, out_valid, op_count and carry_count stay 0.
- After reset, drive in_valid=1 with a=1,b=1,cin=1 for one cycle, then in_valid=0 -> next cycle s_q=1, carry_out_q=1, out_valid=1; the following cycle out_valid=0 with s_q=1 held; op_count=1, carry_count=1.
- Stream all 8 combinations with in_valid=1 -> registered outputs match the truth table one cycle later; op_count=8, carry_count=4.
- With CNT_W=2, run 5 accepted operations of 1,1,0 -> op_count=3 and carry_count=3, both saturated.
- Assert rst_n=0 for one edge while in_valid=1 mid-stream -> all registered outputs and counters are 0 after that edge; operation resumes on the next edge.
